// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing round sequencer.
package guess_pkg;

    // Round sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Hint encoding reported after each checked guess.
    localparam logic [1:0] HINT_NONE  = 2'b00;
    localparam logic [1:0] HINT_LOW   = 2'b01;
    localparam logic [1:0] HINT_HIGH  = 2'b10;
    localparam logic [1:0] HINT_EQUAL = 2'b11;

    // Round length in seconds per difficulty.
    localparam logic [6:0] SECS_EASY = 7'd30;
    localparam logic [6:0] SECS_MED  = 7'd60;
    localparam logic [6:0] SECS_HARD = 7'd90;

    // Difficulty digit to round length; digit 0 is played as difficulty 1.
    function automatic logic [6:0] digit_to_secs(input logic [1:0] digit);
        logic [6:0] secs;
        case (digit)
            2'd2:    secs = SECS_MED;
            2'd3:    secs = SECS_HARD;
            default: secs = SECS_EASY;
        endcase
        return secs;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and raises a
// single-cycle tick on the terminal count. clr restarts the second.
module sec_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_tick_div_range
        $error("TICK_DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick is decoded from the registered count so it is glitch-free.
    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, then wrap on terminal count, else hold when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: latches difficulty and
// secret on start, runs a tick-gated countdown, checks guesses through a
// valid/ready handshake and declares WIN or LOSE.
// Optional feature: define GUESS_LIMIT_EN to cap the number of guesses at
// MAX_GUESSES (a wrong guess reaching the cap loses the round).
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned MAX_GUESSES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] Max_digit,
    input  logic [9:0] secret,
    input  logic [9:0] guess,
    input  logic       guess_valid,
    output logic       guess_ready,
    output logic [6:0] seconds_left,
    output logic [1:0] hint,
    output logic       win,
    output logic       lose,
    output logic       running
);

    // The guess counter is 4 bits wide.
    if (MAX_GUESSES < 1 || MAX_GUESSES > 15) begin : g_max_guesses_range
        $error("MAX_GUESSES must be in 1..15");
    end

    state_t     state_q, state_d;
    logic [6:0] sec_q, sec_d;
    logic [1:0] hint_q, hint_d;
    logic [9:0] secret_q, secret_d;
    logic [9:0] guess_q, guess_d;
    logic       tick;
    logic       tick_clr;
    logic       last_tick;
    logic       live;

`ifdef GUESS_LIMIT_EN
    localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);
    logic [3:0] gcnt_q, gcnt_d;
`endif

    assign live = (state_q == ST_RUN) || (state_q == ST_CHECK);

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .en    (live),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // The tick that takes the countdown from 1 to 0 ends the round.
    assign last_tick = tick && (sec_q == 7'd1);

    // Next-state logic for the round sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        hint_d   = hint_q;
        secret_d = secret_q;
        guess_d  = guess_q;
        tick_clr = 1'b0;
`ifdef GUESS_LIMIT_EN
        gcnt_d   = gcnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    sec_d    = digit_to_secs(Max_digit);
                    hint_d   = HINT_NONE;
                    secret_d = secret;
                    tick_clr = 1'b1;
`ifdef GUESS_LIMIT_EN
                    gcnt_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (tick && sec_q != 7'd0) begin
                    sec_d = sec_q - 7'd1;
                end
                // Timeout beats a simultaneous guess; the guess is dropped.
                if (last_tick) begin
                    state_d = ST_LOSE;
                end else if (guess_valid) begin
                    guess_d = guess;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (tick && sec_q != 7'd0) begin
                    sec_d = sec_q - 7'd1;
                end
                if (guess_q < secret_q) begin
                    hint_d = HINT_LOW;
                end else if (guess_q > secret_q) begin
                    hint_d = HINT_HIGH;
                end else begin
                    hint_d = HINT_EQUAL;
                end
`ifdef GUESS_LIMIT_EN
                gcnt_d = gcnt_q + 4'd1;
`endif
                // An equal guess wins even if the final tick lands now.
                if (guess_q == secret_q) begin
                    state_d = ST_WIN;
                end else if (last_tick) begin
                    state_d = ST_LOSE;
`ifdef GUESS_LIMIT_EN
                end else if (gcnt_q + 4'd1 == MAX_G) begin
                    state_d = ST_LOSE;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, countdown, hint and guess count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sec_q   <= 7'd0;
            hint_q  <= HINT_NONE;
`ifdef GUESS_LIMIT_EN
            gcnt_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            hint_q  <= hint_d;
`ifdef GUESS_LIMIT_EN
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    // Latched secret and captured guess; only meaningful once a round starts.
    always_ff @(posedge clk) begin
        secret_q <= secret_d;
        guess_q  <= guess_d;
    end

    assign guess_ready  = (state_q == ST_RUN) && !last_tick;
    assign seconds_left = sec_q;
    assign hint         = hint_q;
    assign win          = (state_q == ST_WIN);
    assign lose         = (state_q == ST_LOSE);
    assign running      = live;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed testbench for guess_round_ctrl with TICK_DIV=4, MAX_GUESSES=3.
module tb_guess_round_ctrl;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] Max_digit = 2'd1;
    logic [9:0] secret = 10'd0;
    logic [9:0] guess = 10'd0;
    logic       guess_valid = 1'b0;
    logic       guess_ready;
    logic [6:0] seconds_left;
    logic [1:0] res_hint;
    logic       win;
    logic       lose;
    logic       running;
    logic [3:0] flags;

    int checks = 0;
    int failures = 0;

    assign flags = {running, guess_ready, win, lose};

    guess_round_ctrl #(
        .TICK_DIV    (TD),
        .MAX_GUESSES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .Max_digit    (Max_digit),
        .secret       (secret),
        .guess        (guess),
        .guess_valid  (guess_valid),
        .guess_ready  (guess_ready),
        .seconds_left (seconds_left),
        .hint         (res_hint),
        .win          (win),
        .lose         (lose),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] dig, input logic [9:0] sec);
        Max_digit = dig;
        secret = sec;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_guess(input logic [9:0] g);
        guess = g;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        start = 1'b1;
        guess_valid = 1'b1;
        do_reset();
        start = 1'b0;
        guess_valid = 1'b0;
        checks++;
        if (seconds_left !== 7'd0) begin
            failures++; $display("FAIL reset_secs got=%0d exp=0", seconds_left);
        end
        checks++;
        if (res_hint !== 2'b00) begin
            failures++; $display("FAIL reset_hint got=%b exp=00", res_hint);
        end
        checks++;
        if (flags !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", flags);
        end
    endtask

    task automatic test_countdown();
        do_start(2'd1, 10'd500);
        checks++;
        if (seconds_left !== 7'd30 || flags !== 4'b1100) begin
            failures++; $display("FAIL cd_load secs=%0d flags=%b exp 30/1100", seconds_left, flags);
        end
        steps(TD - 1);
        checks++;
        if (seconds_left !== 7'd30) begin
            failures++; $display("FAIL cd_pre_tick got=%0d exp=30", seconds_left);
        end
        step();
        checks++;
        if (seconds_left !== 7'd29) begin
            failures++; $display("FAIL cd_first_tick got=%0d exp=29", seconds_left);
        end
        steps(115);
        checks++;
        if (seconds_left !== 7'd1 || flags !== 4'b1000) begin
            failures++; $display("FAIL cd_last_sec secs=%0d flags=%b exp 1/1000", seconds_left, flags);
        end
        step();
        checks++;
        if (seconds_left !== 7'd0 || flags !== 4'b0001) begin
            failures++; $display("FAIL cd_lose secs=%0d flags=%b exp 0/0001", seconds_left, flags);
        end
        steps(5);
        checks++;
        if (seconds_left !== 7'd0 || flags !== 4'b0001) begin
            failures++; $display("FAIL cd_lose_hold secs=%0d flags=%b exp 0/0001", seconds_left, flags);
        end
    endtask

    task automatic test_difficulty();
        do_start(2'd0, 10'd500);
        checks++;
        if (seconds_left !== 7'd30) begin
            failures++; $display("FAIL diff_zero got=%0d exp=30", seconds_left);
        end
        do_start(2'd3, 10'd500);
        checks++;
        if (seconds_left !== 7'd30 || flags !== 4'b1100) begin
            failures++; $display("FAIL diff_start_in_run secs=%0d flags=%b exp 30/1100", seconds_left, flags);
        end
        do_reset();
        do_start(2'd3, 10'd500);
        checks++;
        if (seconds_left !== 7'd90) begin
            failures++; $display("FAIL diff_three got=%0d exp=90", seconds_left);
        end
        Max_digit = 2'd0;
        steps(TD);
        checks++;
        if (seconds_left !== 7'd89) begin
            failures++; $display("FAIL diff_midround got=%0d exp=89", seconds_left);
        end
    endtask

    task automatic test_guesses();
        do_reset();
        do_start(2'd2, 10'd500);
        secret = 10'd0;
        checks++;
        if (seconds_left !== 7'd60) begin
            failures++; $display("FAIL g_load got=%0d exp=60", seconds_left);
        end
        guess = 10'd200;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        checks++;
        if (flags !== 4'b1000) begin
            failures++; $display("FAIL g_check_state got=%b exp=1000", flags);
        end
        step();
        checks++;
        if (res_hint !== 2'b01 || flags !== 4'b1100) begin
            failures++; $display("FAIL g_low hint=%b flags=%b exp 01/1100", res_hint, flags);
        end
        do_guess(10'd800);
        checks++;
        if (res_hint !== 2'b10 || flags !== 4'b1100) begin
            failures++; $display("FAIL g_high hint=%b flags=%b exp 10/1100", res_hint, flags);
        end
        guess = 10'd500;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        checks++;
        if (res_hint !== 2'b10 || win !== 1'b0) begin
            failures++; $display("FAIL g_eq_early hint=%b win=%b exp 10/0", res_hint, win);
        end
        step();
        checks++;
        if (res_hint !== 2'b11 || flags !== 4'b0010) begin
            failures++; $display("FAIL g_equal hint=%b flags=%b exp 11/0010", res_hint, flags);
        end
        guess = 10'd200;
        guess_valid = 1'b1;
        steps(3);
        guess_valid = 1'b0;
        checks++;
        if (res_hint !== 2'b11 || flags !== 4'b0010 || seconds_left !== 7'd59) begin
            failures++; $display("FAIL g_win_frozen hint=%b flags=%b secs=%0d exp 11/0010/59", res_hint, flags, seconds_left);
        end
    endtask

    task automatic test_final_tick();
        do_reset();
        do_start(2'd1, 10'd500);
        do_guess(10'd100);
        checks++;
        if (res_hint !== 2'b01) begin
            failures++; $display("FAIL ft_first_hint got=%b exp=01", res_hint);
        end
        steps(117);
        guess = 10'd500;
        guess_valid = 1'b1;
        #1;
        checks++;
        if (guess_ready !== 1'b0 || seconds_left !== 7'd1) begin
            failures++; $display("FAIL ft_ready_drop ready=%b secs=%0d exp 0/1", guess_ready, seconds_left);
        end
        step();
        guess_valid = 1'b0;
        checks++;
        if (flags !== 4'b0001 || res_hint !== 2'b01 || seconds_left !== 7'd0) begin
            failures++; $display("FAIL ft_lose flags=%b hint=%b secs=%0d exp 0001/01/0", flags, res_hint, seconds_left);
        end
        do_start(2'd1, 10'd500);
        steps(118);
        guess = 10'd500;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        checks++;
        if (flags !== 4'b1000 || seconds_left !== 7'd1) begin
            failures++; $display("FAIL ft_check flags=%b secs=%0d exp 1000/1", flags, seconds_left);
        end
        step();
        checks++;
        if (flags !== 4'b0010 || res_hint !== 2'b11 || seconds_left !== 7'd0) begin
            failures++; $display("FAIL ft_win flags=%b hint=%b secs=%0d exp 0010/11/0", flags, res_hint, seconds_left);
        end
    endtask

    task automatic test_reset_midround();
        do_reset();
        do_start(2'd1, 10'd500);
        do_guess(10'd100);
        steps(50);
        checks++;
        if (seconds_left !== 7'd17 || res_hint !== 2'b01) begin
            failures++; $display("FAIL rm_before secs=%0d hint=%b exp 17/01", seconds_left, res_hint);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (seconds_left !== 7'd0 || res_hint !== 2'b00 || flags !== 4'b0000) begin
            failures++; $display("FAIL rm_reset secs=%0d hint=%b flags=%b exp 0/00/0000", seconds_left, res_hint, flags);
        end
        do_start(2'd2, 10'd500);
        checks++;
        if (seconds_left !== 7'd60 || flags !== 4'b1100) begin
            failures++; $display("FAIL rm_reload secs=%0d flags=%b exp 60/1100", seconds_left, flags);
        end
        steps(TD);
        checks++;
        if (seconds_left !== 7'd59) begin
            failures++; $display("FAIL rm_first_tick got=%0d exp=59", seconds_left);
        end
    endtask

    task automatic test_guess_limit();
        do_reset();
        do_start(2'd3, 10'd500);
`ifdef GUESS_LIMIT_EN
        do_guess(10'd100);
        do_guess(10'd900);
        checks++;
        if (flags !== 4'b1100) begin
            failures++; $display("FAIL gl_two_wrong got=%b exp=1100", flags);
        end
        do_guess(10'd101);
        checks++;
        if (flags !== 4'b0001 || res_hint !== 2'b01) begin
            failures++; $display("FAIL gl_limit_lose flags=%b hint=%b exp 0001/01", flags, res_hint);
        end
        do_start(2'd3, 10'd500);
        do_guess(10'd100);
        do_guess(10'd900);
        checks++;
        if (flags !== 4'b1100) begin
            failures++; $display("FAIL gl_restart_cleared got=%b exp=1100", flags);
        end
        do_guess(10'd500);
        checks++;
        if (flags !== 4'b0010 || res_hint !== 2'b11) begin
            failures++; $display("FAIL gl_third_win flags=%b hint=%b exp 0010/11", flags, res_hint);
        end
`else
        for (int i = 0; i < 10; i++) begin
            do_guess(10'(100 + i));
            checks++;
            if (lose !== 1'b0) begin
                failures++; $display("FAIL nl_guess%0d lose=%b exp=0", i, lose);
            end
        end
        checks++;
        if (flags !== 4'b1100 || res_hint !== 2'b01) begin
            failures++; $display("FAIL nl_unlimited flags=%b hint=%b exp 1100/01", flags, res_hint);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_difficulty();
        test_guesses();
        test_final_tick();
        test_reset_midround();
        test_guess_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
